// File: rtl/key_event_pkg.sv
// Shared constants and types for the key event queue: event-code width,
// code typedef and the default parameter set.
package key_event_pkg;

   localparam int CODE_W = 3;

   typedef logic [CODE_W-1:0] code_t;

   localparam int NUM_BTN_DEF      = 7;
   localparam int DB_TICKS_DEF     = 4;
   localparam int FIFO_DEPTH_DEF   = 4;
   localparam int REPEAT_TICKS_DEF = 25;

endpackage

// File: rtl/key_event_queue_if.sv
// Event handshake bundle between the key event queue (master) and its
// consumer (slave).
interface key_event_queue_if;
   import key_event_pkg::*;

   logic              ev_valid;
   code_t             ev_code;
   logic              ev_ready;
   logic [CODE_W-1:0] ev_count;

   modport master (
      output ev_valid,
      output ev_code,
      output ev_count,
      input  ev_ready
   );

   modport slave (
      input  ev_valid,
      input  ev_code,
      input  ev_count,
      output ev_ready
   );

endinterface

// File: rtl/key_debounce.sv
// One push-button channel: 2-flop synchronizer followed by a tick-sampled
// stability counter that toggles the debounced level after DB_TICKS agreeing ticks.
module key_debounce
   import key_event_pkg::*;
#(
   parameter int DB_TICKS = DB_TICKS_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn,
   output logic level
);

   localparam int CNT_W = $clog2(DB_TICKS + 1);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;

   // stage p0/p1: metastability guard for the asynchronous button
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= btn;
         sync_p1 <= sync_p0;
      end
   end

   // Any tick agreeing with the current level restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         level <= 1'b0;
      end else if (tick) begin
         if (sync_p1 != level) begin
            if (cnt == CNT_W'(DB_TICKS - 1)) begin
               level <= ~level;
               cnt   <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

endmodule

// File: rtl/key_event_queue.sv
// Debounced push-button event queue: press edges become pending requests that
// drain lowest-index-first into a small FIFO. Optional auto-repeat: KEY_AUTOREPEAT_EN.
module key_event_queue
   import key_event_pkg::*;
#(
   parameter int NUM_BTN      = NUM_BTN_DEF,
   parameter int DB_TICKS     = DB_TICKS_DEF,
   parameter int FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int REPEAT_TICKS = REPEAT_TICKS_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick,
   input  logic [NUM_BTN-1:0] btn,
   key_event_queue_if.master  ev_if,
   output logic [NUM_BTN-1:0] btn_level,
   output logic               overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       FIFO_DEPTH >= (1 << CODE_W) || NUM_BTN > (1 << CODE_W) ||
       REPEAT_TICKS < 1 || DB_TICKS < 1) begin : g_bad_cfg
      $error("key_event_queue: invalid parameter set");
   end

   logic [NUM_BTN-1:0] level_d;
   logic [NUM_BTN-1:0] rise;
   logic [NUM_BTN-1:0] ev_src;
   logic [NUM_BTN-1:0] pending;
   logic [NUM_BTN-1:0] clr;
   code_t              push_idx;
   logic               push;
   logic               pop;
   logic               full;

   code_t              mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CODE_W-1:0]  count;

   for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
      key_debounce #(
         .DB_TICKS (DB_TICKS)
      ) u_debounce (
         .clk   (clk),
         .rst   (rst),
         .tick  (tick),
         .btn   (btn[i]),
         .level (btn_level[i])
      );
   end

   assign rise = btn_level & ~level_d;

`ifdef KEY_AUTOREPEAT_EN
   localparam int REP_W = $clog2(REPEAT_TICKS + 1);

   logic [NUM_BTN-1:0][REP_W-1:0] rep_cnt;
   logic [NUM_BTN-1:0]            rep_fire;

   always_comb begin
      rep_fire = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         rep_fire[i] = tick && btn_level[i] && (rep_cnt[i] == REP_W'(REPEAT_TICKS - 1));
      end
   end

   // Interval counts ticks spent held since the press (or the last repeat)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
      end else begin
         for (int i = 0; i < NUM_BTN; i++) begin
            if (!btn_level[i]) begin
               rep_cnt[i] <= '0;
            end else if (tick) begin
               rep_cnt[i] <= rep_fire[i] ? '0 : rep_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign ev_src = rise | rep_fire;
`else
   assign ev_src = rise;
`endif

   always_comb begin
      push_idx = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (pending[i]) push_idx = code_t'(i);
      end
   end

   // A full queue still accepts a push when the head leaves in the same clk
   assign full = (count == CODE_W'(FIFO_DEPTH));
   assign pop  = ev_if.ev_valid && ev_if.ev_ready;
   assign push = (|pending) && (!full || pop);
   assign clr  = push ? (NUM_BTN'(1) << push_idx) : '0;

   // stage p0: edge capture into pending requests
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_d  <= '0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         level_d <= btn_level;
         pending <= (pending & ~clr) | ev_src;
         if (|(ev_src & pending & ~clr)) overflow <= 1'b1;
      end
   end

   // stage p1: event storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_idx;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign ev_if.ev_valid = (count != '0);
   assign ev_if.ev_code  = mem[rd_ptr];
   assign ev_if.ev_count = count;

endmodule

// File: tb/tb_key_event_queue.sv
// Scoreboard bench for key_event_queue: expected codes are queued as buttons
// are driven and compared whenever the consumer accepts an event.
module tb_key_event_queue;
   import key_event_pkg::*;

   localparam int NB = 7;
   localparam int DB = 4;

`ifdef KEY_AUTOREPEAT_EN
   localparam int HOLD_EVENTS = 3;
`else
   localparam int HOLD_EVENTS = 1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick = 1'b0;
   logic [NB-1:0] btn = '0;
   logic [NB-1:0] btn_level;
   logic          overflow;

   int    n_cmp = 0;
   int    n_bad = 0;
   int    n_ev  = 0;
   int    n_mark;
   code_t exp_q[$];

   key_event_queue_if ev_if ();

   key_event_queue #(
      .NUM_BTN      (NB),
      .DB_TICKS     (DB),
      .FIFO_DEPTH   (4),
      .REPEAT_TICKS (25)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .btn       (btn),
      .ev_if     (ev_if),
      .btn_level (btn_level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Three settle clocks let btn changes cross the synchronizer first
   task automatic pulse_tick();
      step(3);
      tick = 1'b1;
      step(1);
      tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      repeat (n) pulse_tick();
   endtask

   task automatic drain(input string tag);
      ev_if.ev_ready = 1'b1;
      for (int i = 0; i < 200 && (exp_q.size() != 0 || ev_if.ev_count != 0); i++) step(1);
      chk({tag, "_drained"}, exp_q.size(), 0);
      chk({tag, "_empty"}, ev_if.ev_count, 0);
      ev_if.ev_ready = 1'b0;
   endtask

   task automatic release_all(input string tag);
      btn = '0;
      ticks(DB + 1);
      step(3);
      chk({tag, "_released"}, btn_level, 0);
      chk({tag, "_no_release_ev"}, ev_if.ev_count, 0);
   endtask

   always @(negedge clk) begin
      if (!rst && ev_if.ev_valid && ev_if.ev_ready) begin
         n_ev++;
         if (exp_q.size() == 0) chk("unexpected_event", ev_if.ev_code, 32'hFF);
         else chk("ev_code", ev_if.ev_code, exp_q.pop_front());
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      ev_if.ev_ready = 1'b0;
      step(3);
      chk("rst_valid", ev_if.ev_valid, 0);
      chk("rst_count", ev_if.ev_count, 0);
      chk("rst_code", ev_if.ev_code, 0);
      chk("rst_level", btn_level, 0);
      chk("rst_ovf", overflow, 0);
      rst = 1'b0;
      step(2);

      // single press: level after 4 ticks, ev_valid two clk later
      btn[2] = 1'b1;
      ticks(DB - 1);
      chk("t1_level_early", btn_level, 0);
      pulse_tick();
      chk("t1_level", btn_level, 32'h04);
      chk("t1_valid_e0", ev_if.ev_valid, 0);
      step(1);
      chk("t1_valid_e1", ev_if.ev_valid, 0);
      step(1);
      chk("t1_valid_e2", ev_if.ev_valid, 1);
      chk("t1_code", ev_if.ev_code, 2);
      chk("t1_count", ev_if.ev_count, 1);
      exp_q.push_back(3'd2);
      drain("t1");
      release_all("t1");

      // bounce 1,0,1 then hold
      n_mark = n_ev;
      btn[3] = 1'b1; pulse_tick();
      btn[3] = 1'b0; pulse_tick();
      btn[3] = 1'b1; pulse_tick();
      ticks(2);
      chk("t2_level_early", btn_level, 0);
      pulse_tick();
      chk("t2_level", btn_level, 32'h08);
      exp_q.push_back(3'd3);
      step(2);
      chk("t2_count", ev_if.ev_count, 1);
      drain("t2");
      step(5);
      chk("t2_single", n_ev - n_mark, 1);
      release_all("t2");

      // two buttons debounced on the same clk
      btn[5] = 1'b1;
      btn[1] = 1'b1;
      ticks(DB);
      chk("t3_level", btn_level, 32'h22);
      step(1);
      chk("t3_count_e1", ev_if.ev_count, 0);
      step(1);
      chk("t3_count_e2", ev_if.ev_count, 1);
      chk("t3_head", ev_if.ev_code, 1);
      step(1);
      chk("t3_count_e3", ev_if.ev_count, 2);
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd5);
      drain("t3");
      release_all("t3");

      // five presses into a four-deep queue, then a repeat press of the held-back one
      btn[4:0] = 5'b11111;
      ticks(DB);
      step(5);
      chk("t4_full", ev_if.ev_count, 4);
      chk("t4_ovf_clear", overflow, 0);
      btn[4] = 1'b0;
      ticks(DB);
      btn[4] = 1'b1;
      ticks(DB);
      step(2);
      chk("t4_ovf_set", overflow, 1);
      chk("t4_still_full", ev_if.ev_count, 4);
      for (int i = 0; i < 5; i++) exp_q.push_back(code_t'(i));

      // one pop while full lets the pending press in during the same clk
      ev_if.ev_ready = 1'b1;
      step(1);
      ev_if.ev_ready = 1'b0;
      chk("t5_count", ev_if.ev_count, 4);
      chk("t5_head", ev_if.ev_code, 1);
      drain("t5");
      chk("t5_ovf_sticky", overflow, 1);
      release_all("t5");

      // asynchronous reset with queued events, buttons held through it
      btn[2:0] = 3'b111;
      ticks(DB);
      step(4);
      chk("t6_count", ev_if.ev_count, 3);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      chk("t6_valid", ev_if.ev_valid, 0);
      chk("t6_count_rst", ev_if.ev_count, 0);
      chk("t6_code", ev_if.ev_code, 0);
      chk("t6_level", btn_level, 0);
      chk("t6_ovf", overflow, 0);
      exp_q.delete();
      step(2);
      rst = 1'b0;
      ticks(DB);
      step(4);
      chk("t6_held_count", ev_if.ev_count, 3);
      for (int i = 0; i < 3; i++) exp_q.push_back(code_t'(i));
      drain("t6");
      release_all("t6");

      // long hold of btn[0]
      n_mark = n_ev;
      for (int i = 0; i < HOLD_EVENTS; i++) exp_q.push_back(3'd0);
      ev_if.ev_ready = 1'b1;
      btn[0] = 1'b1;
      ticks(60);
      btn[0] = 1'b0;
      ticks(DB + 1);
      step(4);
      chk("t7_hold_events", n_ev - n_mark, HOLD_EVENTS);
      chk("t7_left", exp_q.size(), 0);
      ev_if.ev_ready = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/key_event_queue.md
KEY_EVENT_QUEUE -- requirements
Module: key_event_queue

Interface
REQ-001 Parameter NUM_BTN, default 7: number of push-button inputs.
REQ-002 Parameter DB_TICKS, default 4: number of consecutive stable ticks required to accept a level change.
REQ-003 Parameter FIFO_DEPTH, default 4: event queue entries; SHALL be a power of two.
REQ-004 Parameter REPEAT_TICKS, default 25: auto-repeat interval in ticks (used only under KEY_AUTOREPEAT_EN).
REQ-005 Port clk  input  1: single system clock; all state SHALL change on its rising edge.
REQ-006 Port rst  input  1: reset, asynchronous, active-high.
REQ-007 Port tick  input  1: one-clk-wide sample strobe from the divider.
REQ-008 Port btn  input  NUM_BTN: raw active-high buttons, asynchronous to clk.
REQ-009 Port ev_valid  output  1: head of queue holds an event.
REQ-010 Port ev_code  output  3: index of the pressed button at the head.
REQ-011 Port ev_ready  input  1: consumer accepts the head.
REQ-012 Port ev_count  output  3: current queue occupancy, 0..FIFO_DEPTH.
REQ-013 Port btn_level  output  NUM_BTN: debounced button levels.
REQ-014 Port overflow  output  1: sticky flag for a lost event.

Function
REQ-015 Each btn bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-016 Per button: on a tick where sync != btn_level, the counter SHALL increment; on a tick where they are equal, it SHALL clear; when the counter reaches DB_TICKS, btn_level SHALL toggle and the counter SHALL clear.
REQ-017 A 0->1 transition of btn_level[i] SHALL set pending[i]; 1->0 transitions SHALL generate no event.
REQ-018 Each clk where pending is nonzero and the queue is not full (or is being popped this cycle), the lowest set pending index SHALL be pushed and its bit cleared: one push per clk.
REQ-019 A new edge on button i while pending[i] is already set SHALL set overflow; pending[i] SHALL remain set.
REQ-020 A pop SHALL occur exactly when ev_valid && ev_ready; ev_code SHALL then advance to the next entry on the following clk.
REQ-021 A simultaneous push and pop when full SHALL be permitted, leaving ev_count unchanged.
REQ-022 Pointers SHALL wrap modulo FIFO_DEPTH; ev_valid SHALL equal (ev_count != 0).
REQ-023 Latency from the btn_level rising edge to ev_valid SHALL be 2 clk with an empty queue and no lower-index pending bits.
REQ-024 overflow SHALL clear only on rst.

Reset
REQ-025 rst SHALL immediately clear synchronizers, debounce counters, btn_level, pending, the queue, ev_valid, ev_code, ev_count and overflow to 0.
REQ-026 Buttons held through rst deassertion SHALL produce an event after DB_TICKS ticks.

Configuration
REQ-027 Macro KEY_AUTOREPEAT_EN defined: while btn_level[i] stays 1, pending[i] SHALL be set again every REPEAT_TICKS ticks after the initial press, subject to the same overflow rule.
REQ-028 Macro KEY_AUTOREPEAT_EN undefined: no repeat counters SHALL exist; one event per press.

Structure
REQ-029 Package key_event_pkg SHALL hold the code width (3), the event-code typedef and the default parameter constants.
REQ-030 Sub-module key_debounce (synchronizer plus counter, one per button) SHALL be instantiated NUM_BTN times; the queue is inline.

Verification
REQ-031 btn[2] held for 4 ticks -> btn_level[2]=1, ev_code=2, ev_valid=1 two clk later, ev_count=1.
REQ-032 btn[3] bounces 1,0,1 across 3 ticks, then holds -> exactly one event, accepted 4 ticks after the last bounce.
REQ-033 btn[5] and btn[1] debounce on the same clk -> events 1 then 5 on consecutive clk.
REQ-034 ev_ready=0, five distinct presses -> ev_count=4 with the fifth pending; a sixth press of the same button -> overflow=1; ev_ready=1 -> the fifth pushed, order preserved.
REQ-035 Full queue, push and pop in the same clk -> ev_count stays 4, FIFO order intact.
REQ-036 rst asserted with 3 queued events -> all outputs 0 asynchronously; with KEY_AUTOREPEAT_EN, holding btn[0] for 60 ticks -> 3 events (press plus 2 repeats).
